// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer beside the E-stage ALU: owns HI/LO, holds results for a
// fixed latency and requests stalls. Optional flush port enabled by `define MDU_FLUSH_EN.
module mdu_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
`ifdef MDU_FLUSH_EN
   input  logic        flush,
`endif
   input  logic        md_en,
   input  logic [3:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic [31:0] md_rdata
);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MFHI  = 4'd7,
      OP_MFLO  = 4'd8
   } md_op_e;

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } state_e;

   localparam logic [7:0] MULT_CNT = 8'(MULT_CYCLES);
   localparam logic [7:0] DIV_CNT  = 8'(DIV_CYCLES);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic        pend_wr_q, pend_wr_d;

   logic        flush_w;
   logic        md_active;
   logic        is_long_op;

`ifdef MDU_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   assign md_active  = md_en && (md_op >= OP_MULT) && (md_op <= OP_MFLO);
   assign is_long_op = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
   assign busy       = (state_q == S_BUSY);
   assign stall      = md_active && busy;
   assign hi_out     = hi_q;
   assign lo_out     = lo_q;
   assign md_rdata   = (md_op == OP_MFHI) ? hi_q : lo_q;

   // ---------------- arithmetic datapath ----------------
   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic               div_signed;
   logic               quo_neg, rem_neg;
   logic        [31:0] div_a, div_b, div_b_safe;
   logic        [31:0] quo_mag, rem_mag;
   logic        [31:0] res_hi, res_lo;
   logic               res_wr;

   assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
   assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

   // Signed divide runs on magnitudes so 0x80000000 / -1 cannot overflow the divider.
   assign div_signed = (md_op == OP_DIV);
   assign quo_neg    = div_signed && (rs_val[31] ^ rt_val[31]);
   assign rem_neg    = div_signed && rs_val[31];
   assign div_a      = (div_signed && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
   assign div_b      = (div_signed && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
   assign div_b_safe = (div_b == 32'd0) ? 32'd1 : div_b;
   assign quo_mag    = div_a / div_b_safe;
   assign rem_mag    = div_a % div_b_safe;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      res_wr = 1'b1;
      unique case (md_op)
         OP_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         OP_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         OP_DIV, OP_DIVU: begin
            res_hi = rem_neg ? (32'd0 - rem_mag) : rem_mag;
            res_lo = quo_neg ? (32'd0 - quo_mag) : quo_mag;
            res_wr = (rt_val != 32'd0);
         end
         default: res_wr = 1'b0;
      endcase
   end

   // ---------------- sequencer ----------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;

      if (flush_w) begin
         state_d   = S_IDLE;
         cnt_d     = 8'd0;
         pend_wr_d = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (md_active && is_long_op) begin
                  pend_hi_d = res_hi;
                  pend_lo_d = res_lo;
                  pend_wr_d = res_wr;
                  cnt_d     = (md_op <= OP_MULTU) ? MULT_CNT : DIV_CNT;
                  state_d   = S_BUSY;
               end else if (md_active && md_op == OP_MTHI) begin
                  hi_d = rs_val;
               end else if (md_active && md_op == OP_MTLO) begin
                  lo_d = rs_val;
               end
            end
            S_BUSY: begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  // A divide by zero still occupies the unit but leaves HI/LO alone.
                  if (pend_wr_q) begin
                     hi_d = pend_hi_q;
                     lo_d = pend_lo_q;
                  end
                  pend_wr_d = 1'b0;
                  state_d   = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end

endmodule
